ex_alu_unit: RTL
================

Name: ex_alu_unit

Overview:
- EX-stage execution unit placed directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit ALU operation code plus the ID/EX operands, and produces a registered result, a zero flag and a branch-taken flag for the EX/MEM stage.
- Single-cycle operations complete in 1 cycle. SLL/SRL use an iterative 1-bit-per-cycle shifter.
- Valid/ready handshakes on both sides let the hazard unit stall the pipeline while a shift is in progress.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W == WIDTH.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented on alu_ctl/op_a/op_b/shamt.
- in_ready  out  1  unit can accept an operation this cycle.
- alu_ctl  in  4  operation code from the ALU control decoder.
- op_a  in  WIDTH  rs operand.
- op_b  in  WIDTH  rt operand or immediate.
- shamt  in  SHAMT_W  shift amount for SLL/SRL.
- out_valid  out  1  result/zero/branch_taken hold a completed operation.
- out_ready  in  1  downstream consumes the result this cycle.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- branch_taken  out  1  branch condition true; valid for codes 8–13 only, otherwise 0.
- busy  out  1  shifter iterating (state SHIFT); used by the hazard unit for stall.

Behaviour:
- Op codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor.
  - 6 sll (op_b << shamt), 7 srl (op_b >> shamt, logical).
  - 8 beq, 9 bne, 10 bge, 11 bgt, 12 ble, 13 blt (signed compare of op_a against op_b).
  - 14 slt (signed), 15 sltu (unsigned).
- Arithmetic: add/sub wrap modulo 2^WIDTH.
- Branch codes:
  - result = {0…0, taken}; branch_taken = taken.
  - zero is computed from result as for every other op.
- slt/sltu: result = {0…0, lt}.
- Accept: a transfer occurs when in_valid && in_ready. Inputs are sampled only on acceptance.
- States: IDLE, SHIFT, DONE.
- Transitions:
  - IDLE, accept of a non-shift op → DONE; outputs registered at that edge (latency 1).
  - IDLE, accept of a shift with shamt==0 → DONE; result = op_b.
  - IDLE, accept of a shift with shamt>0 → SHIFT.
    - Shift register loads op_b and counter loads shamt.
    - Each SHIFT cycle shifts 1 bit and decrements the counter.
    - The cycle the counter reaches 1, the final shift is registered into result and state → DONE.
    - Accept-to-out_valid latency is shamt+1 cycles.
  - DONE: out_valid=1; outputs hold stable until out_ready.
    - out_ready && accept of a new op → behaves as the IDLE transitions above (back-to-back, no bubble).
    - out_ready without accept → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is 0 throughout SHIFT.
- out_valid = (state==DONE). result/zero/branch_taken are don't-care when out_valid=0 but must not change while out_valid=1.
- busy = (state==SHIFT).
- Reset:
  - Values: state IDLE; result 0; zero 0; branch_taken 0; out_valid 0; busy 0; shift counter 0.
  - in_ready is 1 once rst_n deasserts.
  - Reset asserted mid-SHIFT or in DONE aborts the operation; no out_valid is produced for it.
- Undefined/illegal encodings: none; all 16 codes are defined.

Optional Feature:
- ALU_OVERFLOW_EN defined:
  - Adds output port ovf (out, 1), registered with result.
  - ovf = signed overflow for add (0) and sub (1); 0 for all other codes; reset value 0.
- ALU_OVERFLOW_EN undefined: the ovf port and its logic do not exist. Add/sub wrap silently.

Test Plan:
- Reset, then add op_a=0x7FFFFFFF, op_b=1, out_ready=1 → next cycle out_valid=1, result=0x80000000, zero=0; with ALU_OVERFLOW_EN, ovf=1.
- sub 5−5 → result=0, zero=1, branch_taken=0. Then beq 5,5 → branch_taken=1, result=1. Then blt op_a=0xFFFFFFFF, op_b=0 → branch_taken=1.
- sll op_b=1, shamt=31 → busy=1 and in_ready=0 for 31 cycles; out_valid 32 cycles after accept with result=0x80000000. srl shamt=0 op_b=0xABCD → result 0xABCD after 1 cycle.
- Hold out_ready=0 in DONE for 5 cycles with in_valid=1 → in_ready=0, result stable. Raise out_ready → new op accepted that same cycle; next result appears the following cycle.
- slt 0xFFFFFFFF vs 1 → result 1; sltu with the same operands → result 0.
- Assert rst_n=0 at cycle 10 of a shamt=20 shift → out_valid=0 immediately, busy=0, state IDLE; no stale result emitted after reset release.

Source files
------------

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: EX-stage execution unit fed by the ALU control decoder.
// Single-cycle ops register their result on acceptance; SLL/SRL run on an
// iterative 1-bit-per-cycle shifter driven by a down-counter.
// Optional build macro: ALU_OVERFLOW_EN adds the registered signed-overflow
// output ovf for add/sub.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation held; ready to accept
// SHIFT | shifter iterating; counter holds remaining 1-bit steps
// DONE  | result/zero/branch_taken valid and held until out_ready
module ex_alu_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctl,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               branch_taken,
`ifdef ALU_OVERFLOW_EN
    output logic               ovf,
`endif
    output logic               busy
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_BNE  = 4'd9;
    localparam logic [3:0] OP_BGE  = 4'd10;
    localparam logic [3:0] OP_BGT  = 4'd11;
    localparam logic [3:0] OP_BLE  = 4'd12;
    localparam logic [3:0] OP_BLT  = 4'd13;
    localparam logic [3:0] OP_SLT  = 4'd14;
    localparam logic [3:0] OP_SLTU = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               shl_q;

    logic               accept;
    logic               is_shift;
    logic               start_shift;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic               lt_s;
    logic               lt_u;
    logic               eq;
    logic               taken;
    logic [WIDTH-1:0]   alu_res;
    logic               ovf_c;
    logic [WIDTH-1:0]   sh_step;
    logic               sh_last;

    assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == SHIFT);
    assign accept      = in_valid && in_ready;
    assign is_shift    = (alu_ctl == OP_SLL) || (alu_ctl == OP_SRL);
    assign start_shift = is_shift && (shamt != '0);
    assign sh_last     = (cnt_q == SHAMT_W'(1));
    assign sh_step     = shl_q ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    // Single-cycle datapath; a zero-distance shift passes op_b through.
    always_comb begin
        sum     = op_a + op_b;
        diff    = op_a - op_b;
        lt_s    = $signed(op_a) < $signed(op_b);
        lt_u    = op_a < op_b;
        eq      = (op_a == op_b);
        taken   = 1'b0;
        alu_res = '0;
        ovf_c   = 1'b0;
        case (alu_ctl)
            OP_ADD: begin
                alu_res = sum;
                ovf_c   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                ovf_c   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLL,
            OP_SRL:  alu_res = op_b;
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = !eq;
            OP_BGE:  taken = !lt_s;
            OP_BGT:  taken = !lt_s && !eq;
            OP_BLE:  taken = lt_s || eq;
            OP_BLT:  taken = lt_s;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            default: alu_res = '0;
        endcase
        if (alu_ctl >= OP_BEQ && alu_ctl <= OP_BLT) begin
            alu_res = {{(WIDTH-1){1'b0}}, taken};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE with out_ready and a new op is a bubble-free restart.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = start_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (sh_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = start_shift ? SHIFT : DONE;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers and iterative shifter; outputs only change on a new
    // single-cycle accept or on the final shift step, so DONE holds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf          <= 1'b0;
`endif
            sh_q         <= '0;
            cnt_q        <= '0;
            shl_q        <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                sh_q  <= op_b;
                cnt_q <= shamt;
                shl_q <= (alu_ctl == OP_SLL);
            end else begin
                result       <= alu_res;
                zero         <= (alu_res == '0);
                branch_taken <= taken;
`ifdef ALU_OVERFLOW_EN
                ovf          <= ovf_c;
`endif
            end
        end else if (state_q == SHIFT) begin
            sh_q  <= sh_step;
            cnt_q <= cnt_q - SHAMT_W'(1);
            if (sh_last) begin
                result       <= sh_step;
                zero         <= (sh_step == '0);
                branch_taken <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                ovf          <= 1'b0;
`endif
            end
        end
    end

`ifndef ALU_OVERFLOW_EN
    logic unused_ovf;
    assign unused_ovf = ovf_c;
`endif

endmodule
